// File: rtl/sel_scan_pkg.sv
// rtl/sel_scan_pkg.sv - shared types and constants for the selection-window scanner
package sel_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        DONE
    } scan_state_e;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_SCAN_LEN = 2**DEF_ADDR_W;
    localparam int LAST_ADDR    = DEF_SCAN_LEN - 1;

    // Last sweep address for an arbitrary scan length.
    function automatic int last_addr(input int scan_len);
        return scan_len - 1;
    endfunction

endpackage

// File: rtl/sel_window_scan_if.sv
// rtl/sel_window_scan_if.sv - window configuration, trigger and mask output bundle
// master: drives pos_start/pos_end/pos_wr_en/ch_err/scan_trig/abort, observes results
// slave : the scanner; drives rd_en/rd_addr/sel_out/sel_valid/busy/done/trig_drop
interface sel_window_scan_if #(
    parameter int N_CH   = 3,
    parameter int ADDR_W = 8
);
    logic [N_CH*ADDR_W-1:0] pos_start;
    logic [N_CH*ADDR_W-1:0] pos_end;
    logic                   pos_wr_en;
    logic [N_CH-1:0]        ch_err;
    logic                   scan_trig;
    logic                   abort;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [N_CH-1:0]        sel_out;
    logic                   sel_valid;
    logic                   busy;
    logic                   done;
    logic                   trig_drop;

    modport master (
        output pos_start, pos_end, pos_wr_en, ch_err, scan_trig, abort,
        input  rd_en, rd_addr, sel_out, sel_valid, busy, done, trig_drop
    );

    modport slave (
        input  pos_start, pos_end, pos_wr_en, ch_err, scan_trig, abort,
        output rd_en, rd_addr, sel_out, sel_valid, busy, done, trig_drop
    );

endinterface

// File: rtl/sel_window_cmp.sv
// rtl/sel_window_cmp.sv - combinational membership of one address in one window
// Ports: addr_i (sweep address), start_i/end_i (inclusive window), member_o.
// Macro SEL_WRAP_EN: when defined, start > end wraps through the top of the range;
// when undefined such a window is empty.
module sel_window_cmp #(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] start_i,
    input  logic [ADDR_W-1:0] end_i,
    output logic              member_o
);
    logic ordered;
    logic above_start;
    logic below_end;

    assign ordered     = (start_i <= end_i);
    assign above_start = (addr_i >= start_i);
    assign below_end   = (addr_i <= end_i);

`ifdef SEL_WRAP_EN
    assign member_o = ordered ? (above_start & below_end) : (above_start | below_end);
`else
    assign member_o = ordered & above_start & below_end;
`endif

endmodule

// File: rtl/sel_window_scan.sv
// rtl/sel_window_scan.sv - multi-channel selection-window sweep generator
// Ports: clk, rst_n (async active-low), bus (sel_window_scan_if.slave):
//   in : pos_start/pos_end (packed per channel), pos_wr_en, ch_err, scan_trig, abort
//   out: rd_en, rd_addr, sel_out, sel_valid, busy, done, trig_drop
// Macro SEL_WRAP_EN selects wrap-around windows (handled inside sel_window_cmp).
module sel_window_scan
    import sel_scan_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int ADDR_W   = 8,
    parameter int SCAN_LEN = 2**ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    sel_window_scan_if.slave bus
);
    localparam int                WW     = N_CH * ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(last_addr(SCAN_LEN));

    scan_state_e       state_q;
    logic              trig_q;
    logic              edge_w;
    logic [WW-1:0]     sh_start_q;
    logic [WW-1:0]     sh_end_q;
    logic [WW-1:0]     act_start_q;
    logic [WW-1:0]     act_end_q;
    logic [N_CH-1:0]   err_q;
    logic [N_CH-1:0]   member_w;
    logic [N_CH-1:0]   sel_out_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              sel_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              trig_drop_q;

    // trig_q resets high so a trigger already high at reset release is not an edge.
    assign edge_w = bus.scan_trig & ~trig_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_cmp
        sel_window_cmp #(.ADDR_W(ADDR_W)) u_cmp (
            .addr_i   (rd_addr_q),
            .start_i  (act_start_q[k*ADDR_W +: ADDR_W]),
            .end_i    (act_end_q[k*ADDR_W +: ADDR_W]),
            .member_o (member_w[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            trig_q      <= 1'b1;
            sh_start_q  <= '0;
            sh_end_q    <= '0;
            act_start_q <= '0;
            act_end_q   <= '0;
            err_q       <= '0;
            sel_out_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            trig_drop_q <= 1'b0;
        end else begin
            trig_q      <= bus.scan_trig;
            trig_drop_q <= edge_w && (state_q != IDLE);
            done_q      <= 1'b0;

            if (bus.pos_wr_en) begin
                sh_start_q <= bus.pos_start;
                sh_end_q   <= bus.pos_end;
            end

            // Mask pipeline: one cycle behind rd_addr, like a synchronous RAM read.
            sel_valid_q <= rd_en_q;
            sel_out_q   <= rd_en_q ? (member_w & ~err_q) : '0;

            unique case (state_q)
                IDLE: begin
                    if (edge_w) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        // Shadow is read before any same-cycle write lands.
                        act_start_q <= sh_start_q;
                        act_end_q   <= sh_end_q;
                        err_q       <= bus.ch_err;
                        rd_addr_q   <= '0;
                        rd_en_q     <= 1'b1;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        rd_en_q     <= 1'b0;
                        rd_addr_q   <= '0;
                        sel_valid_q <= 1'b0;
                        sel_out_q   <= '0;
                    end else if (rd_addr_q == LAST_A) begin
                        state_q   <= DONE;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        done_q    <= 1'b1;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.sel_out   = sel_out_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.trig_drop = trig_drop_q;

endmodule

// File: tb/tb_sel_window_scan.sv
// tb/tb_sel_window_scan.sv - self-checking bench for sel_window_scan
module tb_sel_window_scan;
    localparam int NC = 3;
    localparam int AW = 8;
    localparam int SL = 256;
`ifdef SEL_WRAP_EN
    localparam int EXP_WRAP_250_5 = 12;
    localparam int EXP_WRAP_7_3   = 253;
`else
    localparam int EXP_WRAP_250_5 = 0;
    localparam int EXP_WRAP_7_3   = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sel_window_scan_if #(.N_CH(NC), .ADDR_W(AW)) bus ();
    sel_window_scan_if #(.N_CH(NC), .ADDR_W(AW)) bus16 ();

    sel_window_scan #(.N_CH(NC), .ADDR_W(AW), .SCAN_LEN(SL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    sel_window_scan #(.N_CH(NC), .ADDR_W(AW), .SCAN_LEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit in_win(input int a, input int s, input int e);
`ifdef SEL_WRAP_EN
        if (s <= e) return (a >= s) && (a <= e);
        return (a >= s) || (a <= e);
`else
        return (s <= e) && (a >= s) && (a <= e);
`endif
    endfunction

    // Timeline model: a sweep is fully described by the cycle its trigger edge was sampled.
    logic [AW-1:0] m_sh_s [NC];
    logic [AW-1:0] m_sh_e [NC];
    logic [AW-1:0] m_ac_s [NC];
    logic [AW-1:0] m_ac_e [NC];
    logic [NC-1:0] m_err;
    bit            m_active = 0;
    bit            m_prev   = 1;
    int            m_te     = 0;
    bit            t_edge, was_busy, in_run;
    int            dp, d;
    bit            e_rd_en = 0, e_valid = 0, e_busy = 0, e_done = 0, e_drop = 0;
    logic [AW-1:0] e_rd_addr = '0;
    logic [NC-1:0] e_sel = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_prev = 1; m_active = 0;
            for (int k = 0; k < NC; k++) begin
                m_sh_s[k] = '0; m_sh_e[k] = '0;
            end
            e_rd_en = 0; e_valid = 0; e_busy = 0; e_done = 0; e_drop = 0;
            e_rd_addr = '0; e_sel = '0;
        end else begin
            t_edge   = bus.scan_trig && !m_prev;
            m_prev   = bus.scan_trig;
            dp       = cyc - 1 - m_te;
            was_busy = m_active && (dp <= SL + 1);
            in_run   = m_active && (dp <= SL);
            e_drop   = t_edge && was_busy;
            if (bus.abort && in_run) m_active = 0;
            if (m_active && dp >= SL + 1) m_active = 0;
            if (t_edge && !was_busy) begin
                m_active = 1; m_te = cyc;
            end
            if (m_active && cyc - m_te == 1) begin
                m_ac_s = m_sh_s; m_ac_e = m_sh_e; m_err = bus.ch_err;
            end
            if (bus.pos_wr_en)
                for (int k = 0; k < NC; k++) begin
                    m_sh_s[k] = bus.pos_start[k*AW +: AW];
                    m_sh_e[k] = bus.pos_end[k*AW +: AW];
                end
            d         = cyc - m_te;
            e_busy    = m_active;
            e_rd_en   = m_active && d >= 1 && d <= SL;
            e_rd_addr = e_rd_en ? AW'(d - 1) : '0;
            e_valid   = m_active && d >= 2 && d <= SL + 1;
            e_done    = m_active && d == SL + 1;
            e_sel     = '0;
            if (e_valid)
                for (int k = 0; k < NC; k++)
                    e_sel[k] = in_win(d - 2, int'(m_ac_s[k]), int'(m_ac_e[k])) && !m_err[k];
        end
    end

    initial forever begin
        @(negedge clk);
        check("outputs{rd_en,rd_addr,sel_out,sel_valid,busy,done,trig_drop}",
              32'({bus.rd_en, bus.rd_addr, bus.sel_out, bus.sel_valid, bus.busy, bus.done, bus.trig_drop}),
              32'({e_rd_en, e_rd_addr, e_sel, e_valid, e_busy, e_done, e_drop}));
    end

    // Per-sweep statistics taken from the DUT, pinned against hand-computed literals.
    int cnt [NC];
    int first [NC];
    int c16 [NC];
    int n_drop = 0, n_done = 0;
    logic [AW-1:0] prev_addr = '0;

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NC; k++) begin
            if (bus.sel_valid && bus.sel_out[k]) begin
                if (cnt[k] == 0) first[k] = int'(prev_addr);
                cnt[k]++;
            end
            if (bus16.sel_valid && bus16.sel_out[k]) c16[k]++;
        end
        if (bus.trig_drop) n_drop++;
        if (bus.done) n_done++;
        prev_addr = bus.rd_addr;
    end

    task automatic clr();
        for (int k = 0; k < NC; k++) begin
            cnt[k] = 0; first[k] = 0; c16[k] = 0;
        end
        n_drop = 0; n_done = 0;
    endtask

    task automatic set_win(input int s0, input int e0, input int s1, input int e1,
                           input int s2, input int e2);
        bus.pos_start = {AW'(s2), AW'(s1), AW'(s0)};
        bus.pos_end   = {AW'(e2), AW'(e1), AW'(e0)};
    endtask

    task automatic wr(input int s0, input int e0, input int s1, input int e1,
                      input int s2, input int e2);
        @(negedge clk);
        set_win(s0, e0, s1, e1, s2, e2);
        bus.pos_wr_en = 1'b1;
        @(negedge clk);
        bus.pos_wr_en = 1'b0;
    endtask

    task automatic trig_pulse(output int tcyc);
        @(negedge clk);
        bus.scan_trig = 1'b1;
        tcyc = cyc + 1;
        @(negedge clk);
        bus.scan_trig = 1'b0;
    endtask

    function automatic bit dn(input int which);
        return (which != 0) ? bus16.done : bus.done;
    endfunction

    task automatic wait_done(input int which, input int tcyc, input int off, input string nm);
        int k = 0;
        while (!dn(which) && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (dn(which)) check(nm, cyc + 1 - tcyc, off);
        else begin
            n_cmp++; n_bad++;
            $display("FAIL %s: done not seen within %0d cycles", nm, k);
        end
        @(negedge clk);
    endtask

    task automatic wait_addr(input int a, input string nm);
        int k = 0;
        while (!(bus.rd_en && bus.rd_addr == AW'(a)) && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (!(bus.rd_en && bus.rd_addr == AW'(a))) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: rd_addr %0d not reached, actual %0d", nm, a, bus.rd_addr);
        end
    endtask

    int t;

    initial begin
        bus.pos_start = '0; bus.pos_end = '0; bus.pos_wr_en = 1'b0;
        bus.ch_err = '0; bus.abort = 1'b0; bus.scan_trig = 1'b1;
        bus16.pos_start = '0; bus16.pos_end = '0; bus16.pos_wr_en = 1'b0;
        bus16.ch_err = '0; bus16.abort = 1'b0; bus16.scan_trig = 1'b0;
        clr();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("trig_held_through_reset_busy", bus.busy, 0);
        check("trig_held_through_reset_done", n_done, 0);
        bus.scan_trig = 1'b0;

        // Sweep 1: plain, single-point and top-of-range windows.
        wr(10, 20, 0, 0, 255, 255);
        clr();
        trig_pulse(t);
        wait_done(0, t, 258, "done_latency_sweep1");
        check("ch0_count", cnt[0], 11);
        check("ch0_first", first[0], 10);
        check("ch1_count", cnt[1], 1);
        check("ch1_first", first[1], 0);
        check("ch2_count", cnt[2], 1);
        check("ch2_first", first[2], 255);

        // Sweep 2: wrap window, latched error, dropped edge and mid-sweep write.
        wr(250, 5, 0, 255, 255, 255);
        bus.ch_err = 3'b010;
        clr();
        trig_pulse(t);
        wait_addr(50, "reach_addr_50");
        bus.ch_err = 3'b000;
        bus.scan_trig = 1'b1;
        set_win(3, 7, 0, 0, 0, 0);
        bus.pos_wr_en = 1'b1;
        @(negedge clk);
        bus.scan_trig = 1'b0;
        bus.pos_wr_en = 1'b0;
        wait_done(0, t, 258, "done_latency_sweep2");
        check("wrap_250_5_count", cnt[0], EXP_WRAP_250_5);
        check("ch_err_masked_count", cnt[1], 0);
        check("ch2_count_sweep2", cnt[2], 1);
        check("trig_drop_pulses", n_drop, 1);

        // Sweep 3: abort at address 100.
        clr();
        trig_pulse(t);
        wait_addr(100, "reach_addr_100");
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_rd_en", bus.rd_en, 0);
        check("abort_rd_addr", bus.rd_addr, 0);
        check("abort_sel_valid", bus.sel_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("new_window_count_before_abort", cnt[0], 5);
        repeat (300) @(negedge clk);
        check("abort_no_done", n_done, 0);

        // Sweep 4: full sweep after abort, with a write landing in the LOAD cycle.
        clr();
        trig_pulse(t);
        set_win(100, 101, 7, 3, 200, 210);
        bus.pos_wr_en = 1'b1;
        @(negedge clk);
        bus.pos_wr_en = 1'b0;
        wait_done(0, t, 258, "done_latency_after_abort");
        check("load_write_not_seen_ch0", cnt[0], 5);
        check("load_write_not_seen_ch1", cnt[1], 1);

        // Sweep 5: the LOAD-cycle write is now active.
        clr();
        trig_pulse(t);
        wait_done(0, t, 258, "done_latency_sweep5");
        check("ch0_count_sweep5", cnt[0], 2);
        check("ch0_first_sweep5", first[0], 100);
        check("wrap_7_3_count", cnt[1], EXP_WRAP_7_3);
        check("ch2_count_sweep5", cnt[2], 11);

        // Short scan instance: latency and truncation at the last address.
        @(negedge clk);
        bus16.pos_start = {8'd0, 8'd14, 8'd2};
        bus16.pos_end   = {8'd15, 8'd20, 8'd5};
        bus16.pos_wr_en = 1'b1;
        @(negedge clk);
        bus16.pos_wr_en = 1'b0;
        clr();
        @(negedge clk);
        bus16.scan_trig = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        bus16.scan_trig = 1'b0;
        wait_done(1, t, 18, "done_latency_len16");
        check("len16_ch0_count", c16[0], 4);
        check("len16_truncated_count", c16[1], 2);
        check("len16_full_count", c16[2], 16);
        check("len16_idle_busy", bus16.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
